// File: rtl/debug_ocimem_arbiter.sv
// OCI RAM port owner: sequences JTAG debug-host commands and CPU Avalon accesses
// onto the single RAM port, with round-robin arbitration when both contend.
module debug_ocimem_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_writedata,
  output logic              cpu_waitrequest,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_RD  = 2'd1,
    JTAG_RD = 2'd2
  } state_e;

  localparam logic GR_CPU  = 1'b0;
  localparam logic GR_JTAG = 1'b1;

  state_e              state_q;
  logic [ADDR_W-1:0]   jtag_addr_q;
  logic                jtag_pend_q;
  logic                jtag_wr_q;
  logic [DATA_W-1:0]   jtag_data_q;
  logic                last_grant_q;
  logic [DATA_W-1:0]   mon_dreg_q;
  logic                mon_ready_q;
  logic                mon_error_q;

  logic                cpu_req;
  logic                in_idle;
  logic                grant_jtag;
  logic                grant_cpu;
  logic                cpu_rd_done;
  logic                jtag_done;
  logic                jtag_cmd;
  logic [ADDR_W-1:0]   jdo_addr;
  logic [DATA_W-1:0]   jdo_data;
  logic                unused_jdo;

  assign jdo_addr   = jdo[ADDR_W+16:17];
  assign jdo_data   = jdo[34:3];
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  // Arbitration and RAM port drive; reset suppresses any grant so no write escapes.
  always_comb begin
    cpu_req     = cpu_read | cpu_write;
    in_idle     = reset_n && (state_q == IDLE);
    grant_jtag  = in_idle && jtag_pend_q && (!cpu_req || (last_grant_q == GR_CPU));
    grant_cpu   = in_idle && cpu_req && !grant_jtag;
    cpu_rd_done = (state_q == CPU_RD);
    jtag_done   = (grant_jtag && jtag_wr_q) || (reset_n && (state_q == JTAG_RD));
    jtag_cmd    = !take_action_ocimem_a && (take_action_ocimem_b || take_no_action_ocimem_a);

    ram_addr        = grant_cpu ? cpu_address : jtag_addr_q;
    ram_wdata       = grant_cpu ? cpu_writedata : jtag_data_q;
    ram_wren        = (grant_cpu && cpu_write) || (grant_jtag && jtag_wr_q);
    cpu_waitrequest = cpu_req && !((grant_cpu && cpu_write) || cpu_rd_done);
    cpu_readdata    = cpu_rd_done ? ram_rdata : '0;
  end

  // FSM plus JTAG command/status registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      jtag_addr_q  <= '0;
      jtag_pend_q  <= 1'b0;
      jtag_wr_q    <= 1'b0;
      jtag_data_q  <= '0;
      last_grant_q <= GR_CPU;
      mon_dreg_q   <= '0;
      mon_ready_q  <= 1'b1;
      mon_error_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_cpu && !cpu_write) state_q <= CPU_RD;
          else if (grant_jtag && !jtag_wr_q) state_q <= JTAG_RD;
        end
        CPU_RD: state_q <= IDLE;
        JTAG_RD: begin
          mon_dreg_q <= ram_rdata;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (grant_jtag || grant_cpu) last_grant_q <= grant_jtag ? GR_JTAG : GR_CPU;

      // An address load overrides the post-access increment.
      if (take_action_ocimem_a) begin
        jtag_addr_q <= jdo_addr;
        mon_error_q <= 1'b0;
      end else if (jtag_done) begin
        jtag_addr_q <= jtag_addr_q + ADDR_W'(1);
      end

      if (jtag_done) begin
        jtag_pend_q <= 1'b0;
        mon_ready_q <= 1'b1;
      end

      if (jtag_cmd) begin
        if (jtag_pend_q) begin
          mon_error_q <= 1'b1;
        end else begin
          jtag_pend_q <= 1'b1;
          mon_ready_q <= 1'b0;
          jtag_wr_q   <= take_action_ocimem_b;
          jtag_data_q <= jdo_data;
        end
      end
    end
  end

  assign MonDReg       = mon_dreg_q;
  assign monitor_ready = mon_ready_q;
  assign monitor_error = mon_error_q;

endmodule
